// File: rtl/fetch_decode_if.sv
// Fetch/decode bus: instruction-memory request/response, PC redirect and
// the decoded-instruction handshake toward the type controller.
interface fetch_decode_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [2:0]      inst_type;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] dec_pc;
    logic            illegal;

    modport master (
        output imem_req_valid, imem_addr, dec_valid, inst_type, rd, rs1, rs2,
               funct3, funct7, imm, dec_pc, illegal,
        input  imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid,
               redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, dec_valid, inst_type, rd, rs1, rs2,
               funct3, funct7, imm, dec_pc, illegal,
        output imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid,
               redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_decode.sv
// PC owner and single-outstanding instruction fetcher; decodes each fetched
// word and holds it until the type controller consumes it.
module fetch_decode #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    fetch_decode_if.master  bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    typedef enum logic [2:0] {T_R = 3'd0, T_I = 3'd1, T_B = 3'd2, T_J = 3'd3, T_U = 3'd4} inst_type_t;

    state_t            r_state, w_state_nxt;
    logic [XLEN-1:0]   r_pc, w_pc_nxt;
    logic              r_drop, w_drop_nxt;
    logic              r_req_valid;
    logic              r_dec_valid;
    logic              w_capture;
    logic              w_hs;

    inst_type_t        r_type, w_type;
    logic [4:0]        r_rd, r_rs1, r_rs2;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic [XLEN-1:0]   r_imm, r_dec_pc;
    logic              r_illegal, w_illegal;
    logic signed [31:0] w_imm32;
    logic [31:0]       w_ins;

    assign w_ins = bus.imem_rdata;
    assign w_hs  = r_req_valid & bus.imem_req_ready;

    always_comb begin
        w_type    = T_R;
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (w_ins[6:0])
            7'b0110011: w_type = T_R;
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_type  = T_I;
                w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            end
            7'b1100011: begin
                w_type  = T_B;
                w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            end
            7'b1101111: begin
                w_type  = T_J;
                w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_type  = T_U;
                w_imm32 = {w_ins[31:12], 12'b0};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Redirect outranks every other event once out of IDLE. A response that
    // coincides with a redirect answers the only outstanding request, so
    // nothing remains in flight and no drop is needed afterwards.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (bus.redirect_valid) w_pc_nxt = bus.redirect_pc;
                if (w_hs) begin
                    w_state_nxt = WAIT;
                    w_drop_nxt  = bus.redirect_valid;
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = bus.redirect_pc;
                    if (bus.imem_rsp_valid) begin
                        w_state_nxt = REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    if (r_drop) begin
                        w_state_nxt = REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = HOLD;
                        w_capture   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = REQ;
                end else if (bus.dec_ready) begin
                    w_pc_nxt    = r_pc + XLEN'(4);
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_req_valid <= 1'b0;
            r_dec_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_req_valid <= (w_state_nxt == REQ);
            r_dec_valid <= (w_state_nxt == HOLD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_type    <= T_R;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_imm     <= '0;
            r_dec_pc  <= '0;
            r_illegal <= 1'b0;
        end else if (w_capture) begin
            r_type    <= w_type;
            r_rd      <= w_ins[11:7];
            r_rs1     <= w_ins[19:15];
            r_rs2     <= w_ins[24:20];
            r_funct3  <= w_ins[14:12];
            r_funct7  <= w_ins[31:25];
            r_imm     <= XLEN'(w_imm32);
            r_dec_pc  <= r_pc;
            r_illegal <= w_illegal;
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.dec_valid      = r_dec_valid;
    assign bus.inst_type      = r_type;
    assign bus.rd             = r_rd;
    assign bus.rs1            = r_rs1;
    assign bus.rs2            = r_rs2;
    assign bus.funct3         = r_funct3;
    assign bus.funct7         = r_funct7;
    assign bus.imm            = r_imm;
    assign bus.dec_pc         = r_dec_pc;
    assign bus.illegal        = r_illegal;

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Front end of the RISCV_core control path, directly upstream of the type controller.
- Owns the PC and fetches one 32-bit instruction at a time over a simple request/response instruction-memory port.
- Decodes each instruction into inst_type, register indices, funct fields and a sign-extended immediate.
- Presents the decoded result to the type controller through a valid/ready handshake and accepts PC redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, width of PC, address and immediate.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid (registered).
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  XLEN  fetch address; equals pc.
- imem_rsp_valid  input  1  instruction data valid this cycle.
- imem_rdata  input  32  fetched instruction.
- redirect_valid  input  1  PC redirect from branch/jump.
- redirect_pc  input  XLEN  redirect target; bits [1:0] must be 0.
- dec_valid  output  1  decoded instruction valid.
- dec_ready  input  1  type controller consumes decoded instruction.
- inst_type  output  3  R=0, I=1, B=2, J=3, U=4 (inst_type_t encoding).
- rd, rs1, rs2  output  5 each  instruction bits [11:7], [19:15], [24:20].
- funct3  output  3  bits [14:12].
- funct7  output  7  bits [31:25].
- imm  output  XLEN  sign-extended immediate for the decoded type; 0 for R.
- dec_pc  output  XLEN  PC of the decoded instruction.
- illegal  output  1  opcode not in the supported set.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc=RESET_PC, state=IDLE, drop=0.
  - All outputs 0 except imem_addr=RESET_PC.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE -> REQ unconditionally on the first clock after reset release.
  - REQ: imem_req_valid=1. Handshake (valid & ready) -> WAIT, with imem_req_valid=0 from the next cycle.
  - WAIT: on imem_rsp_valid:
    - drop=1: discard the data, clear drop, go to REQ.
    - drop=0: register the instruction and decoded fields, set dec_valid=1 from the next cycle, go to HOLD.
  - HOLD: dec_valid=1; outputs stable until consumed. On dec_valid & dec_ready: pc<=pc+4 (wraps modulo 2^XLEN), dec_valid<=0, go to REQ.
- Exactly one outstanding request. imem_rsp_valid in IDLE/REQ/HOLD is ignored.
- Latency: request accepted in cycle N, response in cycle N+k, dec_valid high in cycle N+k+1. Minimum 3 cycles per instruction.
- Redirect: highest priority, evaluated every cycle in every state except IDLE.
  - pc<=redirect_pc and dec_valid<=0.
  - REQ, no handshake same cycle: stay in REQ; the address changes next cycle. Changing the address of an unaccepted request is legal on this port.
  - REQ with handshake same cycle, or in WAIT: go to / stay in WAIT with drop=1.
  - HOLD: go to REQ. A simultaneous dec_ready is ignored (no consume, no pc+4).
  - Redirect and rsp_valid together in WAIT: the response is dropped, drop stays 1 only if the request was issued after the redirect; otherwise go to REQ.
- Decode (opcode = bits [6:0]):
  - 0110011 -> R, imm=0.
  - 0010011, 0000011, 1100111 -> I, imm=sext(ins[31:20]).
  - 1100011 -> B, imm=sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
  - 1101111 -> J, imm=sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
  - 0110111, 0010111 -> U, imm={ins[31:12],12'b0}.
  - Any other opcode: illegal=1, inst_type=R, imm=0, dec_valid still asserted so the controller can trap.
- Reset asserted mid-transaction returns immediately to the reset state. A late response after release arrives in IDLE/REQ and is ignored.

Test Plan:
- Reset release, ready=1, rsp 2 cycles later with 0x00500093 (addi x1,x0,5) -> req at addr 0; dec_valid with inst_type=I, rd=1, rs1=0, imm=5, dec_pc=0; after dec_ready, next req at addr 4.
- Fetch 0x40208033 (sub x0,x1,x2), dec_ready held 0 for 5 cycles -> outputs stable, type R, funct7=0x20, no new request until consumed.
- Fetch 0xFE000EE3 (beq, offset -4) -> type B, imm=0xFFFFFFFC; 0x0000006F -> J, imm=0; 0x12345037 -> U, imm=0x12345000.
- Redirect to 0x100 while in WAIT -> old response discarded, dec_valid stays 0, next req at 0x100.
- Redirect with dec_ready in HOLD -> not consumed, next req at redirect_pc, not pc+4; 0x00000023 (store) -> illegal=1.
- Assert reset during WAIT, release, then deliver the stale response -> ignored; first req at RESET_PC.
